// File: rtl/branch_pred_pipe_pkg.sv
// Shared types and constants for the branch prediction pipeline slice.
// pred_meta_t carries the predictor's fetch-side outputs down the D and E
// pipeline registers. META_PC_W fixes the PC field width and must match the
// XLEN parameter of branch_pred_pipe.
package branch_pred_pipe_pkg;

    localparam int META_PC_W   = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic                 valid;
        logic [META_PC_W-1:0] pc;
        logic                 pred;
        logic [META_PC_W-1:0] npc_pred;
    } pred_meta_t;

    localparam pred_meta_t PRED_META_ZERO = '0;

endpackage

// File: rtl/branch_pred_pipe_stat.sv
// pred_stat_counter: saturating statistics counter.
// Ports:
//   clk, rst : clock, async active-high reset (clears count)
//   en       : count one event this cycle
//   count    : current value; sticks at all-ones instead of wrapping
module pred_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en && (count != {CNT_W{1'b1}}))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/branch_pred_pipe.sv
// branch_pred_pipe: carries predictor metadata (taken bit, predicted target,
// PC) through the D and E registers, resolves the prediction in E against
// the real branch outcome, redirects fetch on a mispredict and squashes the
// wrong-path metadata. Also keeps saturating branch/taken/mispredict counts.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   PCF, PredF, NPC_PredF, ValidF  : fetch-stage predictor outputs
//   StallD, StallE, FlushE         : hazard-unit controls
//   IsBranchE, BranchE, BrNPC      : actual branch resolution in E
//   PCE, PredE, NPC_PredE          : E-stage metadata, to predictor update
//   RedirectE, RedirectPC          : fetch redirect on mispredict
//   BranchCnt, TakenCnt, MispredCnt: statistics
module branch_pred_pipe
    import branch_pred_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  PCF,
    input  logic             PredF,
    input  logic [XLEN-1:0]  NPC_PredF,
    input  logic             ValidF,
    input  logic             StallD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             IsBranchE,
    input  logic             BranchE,
    input  logic [XLEN-1:0]  BrNPC,
    output logic [XLEN-1:0]  PCE,
    output logic             PredE,
    output logic [XLEN-1:0]  NPC_PredE,
    output logic             RedirectE,
    output logic [XLEN-1:0]  RedirectPC,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] TakenCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    pred_meta_t meta_d, meta_e;
    logic       mispred, retire, actual_taken;

    // Flush has priority over stall in both registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            meta_d <= PRED_META_ZERO;
        else if (RedirectE)
            meta_d <= PRED_META_ZERO;
        else if (!StallD)
            meta_d <= '{valid: ValidF, pc: PCF, pred: PredF, npc_pred: NPC_PredF};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            meta_e <= PRED_META_ZERO;
        else if (RedirectE || FlushE)
            meta_e <= PRED_META_ZERO;
        else if (!StallE)
            meta_e <= meta_d;
    end

    assign PCE       = meta_e.pc;
    assign PredE     = meta_e.pred;
    assign NPC_PredE = meta_e.npc_pred;

    assign actual_taken = IsBranchE & BranchE;

    // Wrong direction, wrong target, or a taken prediction on a non-branch
    // (predictor alias) are all mispredicts.
    always_comb begin
        mispred = 1'b0;
        if (meta_e.valid) begin
            if (actual_taken)
                mispred = !meta_e.pred || (meta_e.npc_pred != BrNPC);
            else
                mispred = meta_e.pred;
        end
    end

    // Redirect only on the cycle the instruction actually leaves E, so a
    // stalled mispredict fires exactly once.
    assign RedirectE  = mispred & ~StallE;
    assign RedirectPC = !RedirectE   ? '0
                      : actual_taken ? BrNPC
                      :                meta_e.pc + XLEN'(INSTR_BYTES);

    assign retire = meta_e.valid & ~StallE;

    pred_stat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk(clk), .rst(rst), .en(retire & IsBranchE), .count(BranchCnt)
    );

    pred_stat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk(clk), .rst(rst), .en(retire & actual_taken), .count(TakenCnt)
    );

    pred_stat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk(clk), .rst(rst), .en(RedirectE), .count(MispredCnt)
    );

endmodule

// File: tb/tb_branch_pred_pipe.sv
module tb_branch_pred_pipe;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  PCF, NPC_PredF, BrNPC;
    logic             PredF, ValidF, StallD, StallE, FlushE, IsBranchE, BranchE;
    logic [XLEN-1:0]  PCE, NPC_PredE, RedirectPC;
    logic             PredE, RedirectE;
    logic [CNT_W-1:0] BranchCnt, TakenCnt, MispredCnt;

    int n_asrt = 0;
    int n_fail = 0;

    branch_pred_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .PCF(PCF), .PredF(PredF), .NPC_PredF(NPC_PredF), .ValidF(ValidF),
        .StallD(StallD), .StallE(StallE), .FlushE(FlushE),
        .IsBranchE(IsBranchE), .BranchE(BranchE), .BrNPC(BrNPC),
        .PCE(PCE), .PredE(PredE), .NPC_PredE(NPC_PredE),
        .RedirectE(RedirectE), .RedirectPC(RedirectPC),
        .BranchCnt(BranchCnt), .TakenCnt(TakenCnt), .MispredCnt(MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int b, input int t, input int m);
        chk({tag, "_branch"}, 32'(BranchCnt),  32'(b));
        chk({tag, "_taken"},  32'(TakenCnt),   32'(t));
        chk({tag, "_mispred"},32'(MispredCnt), 32'(m));
    endtask

    // Present one fetch, then two edges later it sits alone in E (D holds a bubble).
    task automatic load_e(input logic [31:0] pc, input logic pred, input logic [31:0] npc);
        PCF = pc; PredF = pred; NPC_PredF = npc; ValidF = 1'b1;
        tick();
        ValidF = 1'b0; PredF = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        PCF = '0; NPC_PredF = '0; BrNPC = '0; PredF = 0; ValidF = 0;
        StallD = 0; StallE = 0; FlushE = 0; IsBranchE = 0; BranchE = 0;

        // Reset state
        tick(); tick();
        chk("rst_pce", PCE, 32'h0);
        chk("rst_prede", 32'(PredE), 32'h0);
        chk("rst_redir", 32'(RedirectE), 32'h0);
        chk_cnt("rst", 0, 0, 0);
        rst = 1'b0;

        // 1: correctly predicted taken branch
        load_e(32'h100, 1'b1, 32'h200);
        chk("t1_pce", PCE, 32'h100);
        chk("t1_prede", 32'(PredE), 32'h1);
        chk("t1_npce", NPC_PredE, 32'h200);
        IsBranchE = 1; BranchE = 1; BrNPC = 32'h200;
        #1;
        chk("t1_redir", 32'(RedirectE), 32'h0);
        chk("t1_rpc", RedirectPC, 32'h0);
        tick();
        IsBranchE = 0; BranchE = 0;
        chk_cnt("t1", 1, 1, 0);

        // 2: predicted not-taken, taken; a valid instr in D must be squashed
        PCF = 32'h300; PredF = 0; NPC_PredF = 0; ValidF = 1;
        tick();
        PCF = 32'h304; PredF = 1; NPC_PredF = 32'h999;
        tick();
        ValidF = 0; PredF = 0;
        chk("t2_pce", PCE, 32'h300);
        IsBranchE = 1; BranchE = 1; BrNPC = 32'h340;
        #1;
        chk("t2_redir", 32'(RedirectE), 32'h1);
        chk("t2_rpc", RedirectPC, 32'h340);
        tick();
        IsBranchE = 0; BranchE = 0;
        chk_cnt("t2", 2, 2, 1);
        chk("t2_e_flushed", PCE, 32'h0);
        tick();
        chk("t2_d_flushed_pce", PCE, 32'h0);
        chk("t2_d_flushed_pred", 32'(PredE), 32'h0);

        // 3a: predicted taken, wrong target
        load_e(32'h400, 1'b1, 32'h200);
        IsBranchE = 1; BranchE = 1; BrNPC = 32'h260;
        #1;
        chk("t3a_redir", 32'(RedirectE), 32'h1);
        chk("t3a_rpc", RedirectPC, 32'h260);
        tick();
        IsBranchE = 0; BranchE = 0;
        chk_cnt("t3a", 3, 3, 2);

        // 3b: predicted taken, not taken, PC+4 wraps
        load_e(32'hFFFF_FFFC, 1'b1, 32'h10);
        IsBranchE = 1; BranchE = 0; BrNPC = 32'h10;
        #1;
        chk("t3b_redir", 32'(RedirectE), 32'h1);
        chk("t3b_rpc", RedirectPC, 32'h0);
        tick();
        IsBranchE = 0;
        chk_cnt("t3b", 4, 3, 3);

        // 4: mispredict held in E by StallE for 3 cycles
        load_e(32'h500, 1'b0, 32'h0);
        IsBranchE = 1; BranchE = 1; BrNPC = 32'h580; StallE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_redir", 32'(RedirectE), 32'h0);
            chk("t4_stall_rpc", RedirectPC, 32'h0);
            tick();
            chk("t4_stall_pce", PCE, 32'h500);
            chk_cnt("t4_stall", 4, 3, 3);
        end
        StallE = 0;
        #1;
        chk("t4_rel_redir", 32'(RedirectE), 32'h1);
        chk("t4_rel_rpc", RedirectPC, 32'h580);
        tick();
        chk_cnt("t4_rel", 5, 4, 4);
        tick();
        IsBranchE = 0; BranchE = 0;
        chk_cnt("t4_after", 5, 4, 4);

        // 5a: FlushE bubbles E even with a valid D
        PCF = 32'h600; PredF = 1; NPC_PredF = 32'h640; ValidF = 1;
        tick();
        ValidF = 0; PredF = 0; FlushE = 1;
        tick();
        FlushE = 0;
        chk("t5a_prede", 32'(PredE), 32'h0);
        chk("t5a_pce", PCE, 32'h0);

        // 5b: non-branch predicted taken (alias)
        load_e(32'h700, 1'b1, 32'h7A0);
        #1;
        chk("t5b_redir", 32'(RedirectE), 32'h1);
        chk("t5b_rpc", RedirectPC, 32'h704);
        tick();
        chk_cnt("t5b", 5, 4, 5);

        // 6: 14 more correctly predicted not-taken branches; 5+14 saturates at 15
        IsBranchE = 1; BranchE = 0; PredF = 0; ValidF = 1;
        for (int i = 0; i < 14; i++) begin
            PCF = 32'h800 + 32'(i * 4);
            tick();
        end
        ValidF = 0;
        tick(); tick();
        IsBranchE = 0;
        chk_cnt("t6_sat", 15, 4, 5);

        // Reset mid-operation with a redirect pending
        load_e(32'h900, 1'b1, 32'h950);
        IsBranchE = 1; BranchE = 1; BrNPC = 32'h960;
        #1;
        chk("t6_pre_redir", 32'(RedirectE), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_redir", 32'(RedirectE), 32'h0);
        chk("t6_rst_rpc", RedirectPC, 32'h0);
        chk("t6_rst_pce", PCE, 32'h0);
        chk("t6_rst_prede", 32'(PredE), 32'h0);
        chk("t6_rst_npce", NPC_PredE, 32'h0);
        chk_cnt("t6_rst", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_pred_pipe.md
Name: branch_pred_pipe

Overview:
Carries the predictor's fetch-stage outputs (taken bit, predicted target, PC) through the D and E pipeline registers, then resolves the prediction in E against the actual branch outcome. Drives the predictor's E-side update inputs. On a wrong prediction it issues a fetch redirect and squashes wrong-path metadata. Keeps saturating branch/taken/mispredict statistics counters. Sits between the branch predictor and the PC-select / hazard logic.

Parameters:
XLEN, 32, address/PC width
CNT_W, 32, width of each statistics counter

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
PCF  in  XLEN  fetch PC
PredF  in  1  predictor taken bit for PCF
NPC_PredF  in  XLEN  predicted target for PCF
ValidF  in  1  F holds a real instruction
StallD  in  1  hold F->D register
StallE  in  1  hold D->E register; E instruction does not retire this cycle
FlushE  in  1  external bubble into E (load-use)
IsBranchE  in  1  E instruction is a conditional branch
BranchE  in  1  actual taken outcome in E
BrNPC  in  XLEN  actual branch target in E
PCE  out  XLEN  E-stage PC, to predictor update port
PredE  out  1  E-stage prediction, to predictor
NPC_PredE  out  XLEN  E-stage predicted target, to predictor
RedirectE  out  1  mispredict; PC-select must load RedirectPC
RedirectPC  out  XLEN  corrected fetch address
BranchCnt  out  CNT_W  resolved conditional branches
TakenCnt  out  CNT_W  resolved branches actually taken
MispredCnt  out  CNT_W  redirects issued

Behaviour:
- Two metadata registers, D and E. Each holds {Valid, PC, Pred, NPC_Pred}. Reset clears every field to 0, so every output is 0 during and after reset.
- D register:
  - Flush (RedirectE): load 0.
  - Else hold (StallD): keep contents.
  - Else load {ValidF, PCF, PredF, NPC_PredF}.
- E register:
  - Flush (RedirectE or FlushE): load 0.
  - Else hold (StallE): keep contents.
  - Else load the D register.
- Flush wins over stall in both registers.
- Mispredict conditions, combinational, all require ValidE:
  - IsBranchE & BranchE & !PredE -> RedirectPC = BrNPC
  - IsBranchE & BranchE & PredE & NPC_PredE != BrNPC -> RedirectPC = BrNPC
  - IsBranchE & !BranchE & PredE -> RedirectPC = PCE + 4
  - !IsBranchE & PredE (alias) -> RedirectPC = PCE + 4
- RedirectE = mispredict & !StallE. It is high for exactly the one cycle the instruction leaves E.
- RedirectPC = 0 when RedirectE is low.
- PCE + 4 is computed modulo 2^XLEN (0xFFFFFFFC wraps to 0).
- Latency:
  - A prediction presented at F appears on PredE two edges later with no stalls.
  - A redirect is combinational in E's cycle. The squash of D and E takes effect at the next posedge.
- Counters update only when ValidE & !StallE (once per instruction):
  - BranchCnt += IsBranchE
  - TakenCnt += IsBranchE & BranchE
  - MispredCnt += RedirectE
- Counters saturate at all-ones and never wrap.
- Simultaneous events:
  - FlushE together with RedirectE: the E register is cleared once.
  - StallD with StallE=0 and no redirect: E loads D, and D keeps its contents (duplicate). The hazard unit must assert FlushE in that case; the block does not police it.
- Reset mid-operation clears all registers and counters immediately (asynchronous). RedirectE drops to 0 in the same cycle.

Decomposition:
- Shared package:
  - typedef pred_meta_t {valid, pc, pred, npc_pred}
  - constant INSTR_BYTES = 4
  - reset constant PRED_META_ZERO
- One natural sub-module: pred_stat_counter, a saturating CNT_W counter with enable. Instantiated three times.
- Resolution logic stays inline.

Test Plan:
1. Reset, then PCF=0x100, PredF=1, NPC_PredF=0x200, ValidF=1, no stalls -> after 2 edges PCE=0x100, PredE=1, NPC_PredE=0x200; with IsBranchE=1, BranchE=1, BrNPC=0x200 -> RedirectE=0, BranchCnt=1, TakenCnt=1.
2. Predicted not-taken, actually taken: PredE=0, BranchE=1, BrNPC=0x340 -> RedirectE=1, RedirectPC=0x340. Next edge: D and E Valid=0. MispredCnt=1.
3. Predicted taken to 0x200, actual target 0x260 -> RedirectPC=0x260. Predicted taken, not taken at PCE=0xFFFFFFFC -> RedirectPC=0x00000000.
4. Mispredict in E with StallE=1 for 3 cycles -> RedirectE=0 and counters frozen while stalled. Redirect fires once on the release cycle. MispredCnt increments by exactly 1.
5. FlushE=1 with a valid D -> E becomes Valid=0 and PredE=0. A non-branch with PredE=1 -> RedirectPC=PCE+4, BranchCnt unchanged.
6. Preload counters near saturation (drive 2^CNT_W-1 events, or CNT_W=4 with 16 branches) -> BranchCnt holds 0xF. Assert rst mid-run -> all outputs 0 immediately.
